// File: rtl/mad_unit.sv
// Execute-stage multiply/divide unit: multi-cycle mult/multu/div/divu with
// architectural HI/LO registers and a busy flag for the hazard unit.
module mad_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        opA_q;
  logic [31:0]        opB_q;
  logic [1:0]         opSel_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic [31:0]        divisor_d;
  logic [63:0]        sProd_d;
  logic [63:0]        uProd_d;
  logic [31:0]        hiNext_d;
  logic [31:0]        loNext_d;
  logic               startOk;

  assign startOk = start && !cancel && !op[2];

  // Dividing by 1 covers both b=0 (result discarded) and 0x80000000/-1,
  // whose quotient -2^31 with remainder 0 is exactly the required result.
  always_comb begin
    divisor_d = opB_q;
    if ((opB_q == 32'd0) || (opA_q == 32'h8000_0000 && opB_q == 32'hFFFF_FFFF))
      divisor_d = 32'd1;
    sProd_d  = $signed({{32{opA_q[31]}}, opA_q}) * $signed({{32{opB_q[31]}}, opB_q});
    uProd_d  = {32'd0, opA_q} * {32'd0, opB_q};
    hiNext_d = hi_q;
    loNext_d = lo_q;
    case (opSel_q)
      2'b00: {hiNext_d, loNext_d} = sProd_d;
      2'b01: {hiNext_d, loNext_d} = uProd_d;
      2'b10: if (opB_q != 32'd0) begin
        loNext_d = $signed(opA_q) / $signed(divisor_d);
        hiNext_d = $signed(opA_q) % $signed(divisor_d);
      end
      2'b11: if (opB_q != 32'd0) begin
        loNext_d = opA_q / divisor_d;
        hiNext_d = opA_q % divisor_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      opSel_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startOk) begin
            opA_q   <= a;
            opB_q   <= b;
            opSel_q <= op[1:0];
            cnt_q   <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_q <= RUN;
          end else if (!cancel) begin
            if (hi_we) hi_q <= a;
            if (lo_we) lo_q <= a;
          end
        end
        RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= hiNext_d;
            lo_q    <= loNext_d;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mad_unit.md
Name: mad_unit

Overview:
- Execute-stage multiply/divide unit. It consumes the multiply/divide control fields that the ID/EX pipeline register delivers: start, op select, HI/LO write enables and the operand buses.
- It performs multi-cycle mult/multu/div/divu and holds the architectural HI/LO registers.
- It raises a busy flag that the hazard unit uses to stall dependent instructions.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy duration for div/divu (must be ≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage MAD_start; begin operation selected by op.
- op  in  3  E-stage MAD_sel: 000 mult, 001 multu, 010 div, 011 divu. Other codes: no operation.
- hi_we  in  1  E-stage HI_En; mthi writes HI.
- lo_we  in  1  E-stage LO_En; mtlo writes LO.
- cancel  in  1  exception/flush in this cycle; suppresses start, hi_we and lo_we.
- a  in  32  E-stage forwarded rs operand.
- b  in  32  E-stage forwarded rt operand.
- busy  out  1  operation in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (sync, active-high):
  - busy=0, hi=0, lo=0.
  - Counter and latched operands cleared.
  - Reset mid-operation aborts it; no HI/LO update ever occurs from the aborted operation.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter cnt).
- Accepted start: edge k with start=1, cancel=0, busy=0 and op∈{000..011}.
  - Latch a, b and op.
  - cnt = MULT_CYCLES or DIV_CYCLES according to op.
  - Go to RUN.
  - Start with an undefined op code: ignored.
- RUN:
  - busy=1 from cycle k+1 through k+N.
  - cnt decrements each edge.
  - On the edge where cnt reaches 0 (edge k+N): write HI/LO from the latched operands, return to IDLE, busy=0.
  - New HI/LO values are visible in the same cycle busy falls.
- Arithmetic, on the 32-bit operands latched at start:
  - mult: signed 64-bit product; HI = product[63:32], LO = product[31:0].
  - multu: unsigned 64-bit product; HI = product[63:32], LO = product[31:0].
  - div: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned; LO = quotient, HI = remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (b=0): operation still runs for DIV_CYCLES with busy asserted; HI and LO left unchanged.
- mthi/mtlo:
  - When busy=0 and cancel=0: hi_we writes hi<=a on that edge (single cycle); lo_we writes lo<=a likewise.
  - When busy=1: hi_we and lo_we are ignored.
- start while busy=1: ignored. The hazard unit guarantees this does not occur; the unit must still not corrupt the running operation.
- Simultaneous start and hi_we/lo_we in the same cycle: start has priority; the write is dropped.
- cancel=1: start, hi_we and lo_we are all ignored that cycle. An operation already in RUN is not affected by cancel and completes normally.
- Stall contract for the hazard unit, documented here for consistency: mfhi/mflo/mult/div in the D stage stall while (start | busy). The unit itself does not generate stall.
- hi and lo are registered outputs with no combinational path from the inputs.

Test Plan:
- Reset, then mult a=0xFFFFFFFF b=0x00000002:
  - busy=1 for exactly 5 cycles.
  - Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - hi/lo hold their old values (0) while busy.
- multu with the same operands: hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div a=0xFFFFFFF9 (−7) b=2:
  - busy for 10 cycles.
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7 b=0, with prior hi=0x11, lo=0x22: busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Writes around a running operation:
  - lo_we with a=0xABCD in IDLE: lo=0xABCD next cycle.
  - hi_we asserted during RUN of a mult: ignored; the final hi comes from the mult.
  - start together with cancel=1: busy stays 0.
- Reset asserted in cycle 3 of a div: busy=0, hi=lo=0 the next cycle; no later update from the aborted div.
